// File: rtl/quad_irq_ctrl.sv
// Interrupt aggregator: latches up to NUM_SRC requests (edge or level), masks them and
// drives one registered CPU interrupt; programmed and claimed over a Wishbone-style slave port.
module quad_irq_ctrl #(
    parameter int NUM_SRC = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_SRC-1:0] i_irq_src,
    input  logic [31:0]        i_wb_addr,
    input  logic [31:0]        i_wb_dat,
    input  logic               i_wb_we,
    input  logic               i_wb_cyc,
    output logic [31:0]        o_wb_dat,
    output logic               o_wb_ack,
    output logic               o_irq
);

    localparam int PAD = 32 - NUM_SRC;

    logic [NUM_SRC-1:0] src_q, src_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] mode_q, mode_d;
    logic               irq_q, irq_d;
    logic               ack_q, ack_d;
    logic [31:0]        dat_q, dat_d;

    logic [NUM_SRC-1:0] active;
    logic [NUM_SRC-1:0] set_vec;
    logic [NUM_SRC-1:0] claim_clr;
    logic [NUM_SRC-1:0] claim_take;
    logic [NUM_SRC-1:0] w1c_clr;
    logic [4:0]         claim_id;
    logic [31:0]        rd_data;
    logic               accept;
    logic               wr_acc;
    logic               rd_acc;

    logic unused_bits;
    assign unused_bits = ^{i_wb_addr[31:5], i_wb_addr[1:0], i_wb_dat[31:NUM_SRC]};

    assign active = pending_q & enable_q;

    // Edge sources set only on a 0->1 transition; level sources set every high cycle.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign set_vec[gi] = mode_q[gi] ? (i_irq_src[gi] & ~src_q[gi]) : i_irq_src[gi];
        end
    endgenerate

    // Scan from the top down so the lowest active index is the one left standing.
    always_comb begin
        claim_id  = '0;
        claim_clr = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                claim_id     = 5'(i + 1);
                claim_clr    = '0;
                claim_clr[i] = 1'b1;
            end
        end
    end

    always_comb begin
        accept     = i_wb_cyc & ~ack_q;
        wr_acc     = accept & i_wb_we;
        rd_acc     = accept & ~i_wb_we;
        w1c_clr    = '0;
        claim_take = '0;
        enable_d   = enable_q;
        mode_d     = mode_q;
        rd_data    = '0;
        case (i_wb_addr[4:2])
            3'd0: begin
                rd_data = {{PAD{1'b0}}, pending_q};
                if (wr_acc) w1c_clr = i_wb_dat[NUM_SRC-1:0];
            end
            3'd1: begin
                rd_data = {{PAD{1'b0}}, enable_q};
                if (wr_acc) enable_d = i_wb_dat[NUM_SRC-1:0];
            end
            3'd2: begin
                rd_data = {{PAD{1'b0}}, mode_q};
                if (wr_acc) mode_d = i_wb_dat[NUM_SRC-1:0];
            end
            3'd3: rd_data = {{PAD{1'b0}}, active};
            3'd4: begin
                rd_data = {27'd0, claim_id};
                if (rd_acc) claim_take = claim_clr;
            end
            default: rd_data = '0;
        endcase

        src_d     = i_irq_src;
        // A new set wins over a clear landing on the same bit in the same cycle.
        pending_d = (pending_q & ~(w1c_clr | claim_take)) | set_vec;
        irq_d     = |active;
        ack_d     = accept;
        dat_d     = rd_acc ? rd_data : 32'd0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            src_q     <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            mode_q    <= '0;
            irq_q     <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            src_q     <= src_d;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            irq_q     <= irq_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
        end
    end

    assign o_irq    = irq_q;
    assign o_wb_ack = ack_q;
    assign o_wb_dat = dat_q;

endmodule
